// File: rtl/instr_sequencer.sv
// instr_sequencer
//   Multi-cycle sequencer for the 32-bit single-issue datapath. Owns the PC,
//   fetches from instruction memory over a req/ack handshake, holds the fetched
//   instruction stable for the combinational decoder, times the EXECUTE window
//   and issues one register-file write strobe per retired instruction.
//
// Ports
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   start            begin execution from START_PC (honoured in IDLE/HALT/FAULT)
//   stop             return to IDLE at the next instruction boundary
//   imem_req/addr    fetch request and address (addr = pc)
//   imem_ack/data    fetch data valid strobe and instruction word
//   instr            latched instruction for the decoder
//   exec_en          ALU operand/result valid window
//   reg_we           one-cycle register-file write strobe
//   pc               current program counter
//   busy/halted/fault  status flags decoded from the state
//   retired          retired-instruction count (wraps at 2**16)
//   state_dbg        current FSM state encoding, for observation only
//
// Fetch handshake: imem_req is high for every cycle spent in FETCH and drops
// the cycle after imem_ack is seen; imem_data is captured only in a cycle
// where imem_req and imem_ack are both high. A word offered while imem_req is
// low is ignored.

module instr_sequencer #(
    parameter int PC_W        = 8,
    parameter int START_PC    = 0,
    parameter int EXEC_CYCLES = 1,
    parameter int TIMEOUT     = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            stop,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_data,
    output logic [31:0]     instr,
    output logic            exec_en,
    output logic            reg_we,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            halted,
    output logic            fault,
    output logic [15:0]     retired,
    output logic [2:0]      state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5,
        S_FAULT     = 3'd6
    } state_t;

    // Counters only ever reach TIMEOUT / EXEC_CYCLES, so size them for that.
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam int EXEC_W = $clog2(EXEC_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(TIMEOUT - 1);
    localparam logic [EXEC_W-1:0] EXEC_LAST  = EXEC_W'(EXEC_CYCLES - 1);
    localparam logic [PC_W-1:0]   START_ADDR = PC_W'(START_PC);
    localparam logic [31:0]       HALT_WORD  = 32'hFFFF_FFFF;

    state_t            state;
    state_t            state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [EXEC_W-1:0] exec_cnt;
    logic              stop_seen;   // stop observed during the current instruction

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and state-decoded outputs
    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        exec_en    = 1'b0;
        reg_we     = 1'b0;
        busy       = 1'b0;
        halted     = 1'b0;
        fault      = 1'b0;
        case (state)
            S_IDLE, S_HALT, S_FAULT: begin
                halted = (state == S_HALT);
                fault  = (state == S_FAULT);
                if (start) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                imem_req = 1'b1;
                busy     = 1'b1;
                // An ack on the final allowed cycle still completes the fetch.
                if (imem_ack) begin
                    state_next = S_DECODE;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_next = S_FAULT;
                end
            end
            S_DECODE: begin
                busy = 1'b1;
                if (instr == HALT_WORD) begin
                    state_next = S_HALT;
                end else begin
                    state_next = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                busy    = 1'b1;
                exec_en = 1'b1;
                if (exec_cnt == EXEC_LAST) begin
                    state_next = S_WRITEBACK;
                end
            end
            S_WRITEBACK: begin
                busy = 1'b1;
                // ALU opcode 0 means the instruction produces no register result.
                reg_we = (instr[18:15] != 4'b0000);
                if (stop_seen || stop) begin
                    state_next = S_IDLE;
                end else begin
                    state_next = S_FETCH;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign imem_addr = pc;
    assign state_dbg = state;

    // Datapath registers: pc, instruction latch, counters, stop flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= START_ADDR;
            instr     <= '0;
            retired   <= '0;
            wait_cnt  <= '0;
            exec_cnt  <= '0;
            stop_seen <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_HALT, S_FAULT: begin
                    stop_seen <= 1'b0;
                    if (start) begin
                        pc       <= START_ADDR;
                        retired  <= '0;
                        wait_cnt <= '0;
                    end
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        instr <= imem_data;
                    end
                    wait_cnt <= wait_cnt + 1'b1;
                    if (stop) begin
                        stop_seen <= 1'b1;
                    end
                end
                S_DECODE: begin
                    exec_cnt <= '0;
                    if (stop) begin
                        stop_seen <= 1'b1;
                    end
                end
                S_EXECUTE: begin
                    exec_cnt <= exec_cnt + 1'b1;
                    if (stop) begin
                        stop_seen <= 1'b1;
                    end
                end
                S_WRITEBACK: begin
                    pc        <= pc + 1'b1;       // natural wrap modulo 2**PC_W
                    retired   <= retired + 1'b1;
                    wait_cnt  <= '0;
                    stop_seen <= 1'b0;
                end
                default: begin
                    stop_seen <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer
//   Two sequencer instances share the stimulus inputs; the one not under test
//   is held in reset. dut_a uses the default parameters, dut_b a 2-bit PC with
//   a non-zero start address, a 3-cycle EXECUTE window and a short timeout.
//   The reference model tracks pc / retired count arithmetically and derives
//   each instruction's timeline from the fetch delay and the execute length.

module tb_instr_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b, start, stop, imem_ack;
    logic [31:0] imem_data;

    logic        a_req, a_exec, a_we, a_busy, a_halted, a_fault;
    logic [7:0]  a_addr, a_pc;
    logic [31:0] a_instr;
    logic [15:0] a_ret;
    logic [2:0]  a_state;

    logic        b_req, b_exec, b_we, b_busy, b_halted, b_fault;
    logic [1:0]  b_addr, b_pc;
    logic [31:0] b_instr;
    logic [15:0] b_ret;
    logic [2:0]  b_state;

    instr_sequencer #(.PC_W(8), .START_PC(0), .EXEC_CYCLES(1), .TIMEOUT(15)) dut_a (
        .clk(clk), .rst(rst_a), .start(start), .stop(stop),
        .imem_req(a_req), .imem_addr(a_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .instr(a_instr), .exec_en(a_exec), .reg_we(a_we), .pc(a_pc),
        .busy(a_busy), .halted(a_halted), .fault(a_fault), .retired(a_ret),
        .state_dbg(a_state)
    );

    instr_sequencer #(.PC_W(2), .START_PC(2), .EXEC_CYCLES(3), .TIMEOUT(3)) dut_b (
        .clk(clk), .rst(rst_b), .start(start), .stop(stop),
        .imem_req(b_req), .imem_addr(b_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .instr(b_instr), .exec_en(b_exec), .reg_we(b_we), .pc(b_pc),
        .busy(b_busy), .halted(b_halted), .fault(b_fault), .retired(b_ret),
        .state_dbg(b_state)
    );

    // View of whichever instance is under test
    logic        sel;
    logic        v_req, v_exec, v_we, v_busy, v_halted, v_fault;
    logic [31:0] v_addr, v_pc, v_instr, v_ret;

    always_comb begin
        if (sel) begin
            v_req = b_req;  v_exec = b_exec;  v_we = b_we;  v_busy = b_busy;
            v_halted = b_halted;  v_fault = b_fault;
            v_addr = 32'(b_addr);  v_pc = 32'(b_pc);  v_instr = b_instr;  v_ret = 32'(b_ret);
        end else begin
            v_req = a_req;  v_exec = a_exec;  v_we = a_we;  v_busy = a_busy;
            v_halted = a_halted;  v_fault = a_fault;
            v_addr = 32'(a_addr);  v_pc = 32'(a_pc);  v_instr = a_instr;  v_ret = 32'(a_ret);
        end
    end

    // Reference model state and per-instance configuration
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] m_pc, m_ret;
    logic [31:0] cur_mod, cur_start;
    int          cur_exec, cur_timeout;

    typedef struct {
        logic [31:0] word;
        int          delay;
        logic        we;
        logic        halt;
    } vec_t;

    vec_t vecs[7];

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    task automatic checkv(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic use_dut(input logic s);
        sel = s;
        if (s) begin
            cur_exec = 3;  cur_mod = 32'd4;   cur_start = 32'd2;  cur_timeout = 3;
        end else begin
            cur_exec = 1;  cur_mod = 32'd256; cur_start = 32'd0;  cur_timeout = 15;
        end
    endtask

    function automatic logic writes_reg(input logic [31:0] w);
        return (w[18:15] != 4'b0000);
    endfunction

    task automatic check_reset_values(input string tag);
        checkv({tag, "_pc"}, v_pc, cur_start);
        checkv({tag, "_instr"}, v_instr, 32'd0);
        checkv({tag, "_retired"}, v_ret, 32'd0);
        check1({tag, "_req"}, v_req, 1'b0);
        check1({tag, "_exec"}, v_exec, 1'b0);
        check1({tag, "_we"}, v_we, 1'b0);
        check1({tag, "_busy"}, v_busy, 1'b0);
        check1({tag, "_halted"}, v_halted, 1'b0);
        check1({tag, "_fault"}, v_fault, 1'b0);
    endtask

    task automatic apply_reset();
        start = 1'b0;  stop = 1'b0;  imem_ack = 1'b0;
        if (sel) rst_b = 1'b1; else rst_a = 1'b1;
        tick();
        tick();
        check_reset_values("reset");
        if (sel) rst_b = 1'b0; else rst_a = 1'b0;
        tick();
        check1("idle_busy", v_busy, 1'b0);
        m_pc = cur_start;
        m_ret = 32'd0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        m_pc = cur_start;
        m_ret = 32'd0;
        check1("start_req", v_req, 1'b1);
        check1("start_fault", v_fault, 1'b0);
        check1("start_halted", v_halted, 1'b0);
        checkv("start_addr", v_addr, cur_start);
        checkv("start_retired", v_ret, 32'd0);
    endtask

    // Runs one instruction starting from the first FETCH cycle.
    // stop_at: -1 none, 0..cur_exec-1 pulse stop in that EXECUTE cycle,
    // 100 pulse stop in the first FETCH cycle.
    task automatic run_instr(input logic [31:0] word, input int delay, input logic exp_we,
                             input logic exp_halt, input int stop_at);
        logic stopped;
        stopped = (stop_at >= 0);
        for (int d = 0; d <= delay; d++) begin
            check1("fetch_req", v_req, 1'b1);
            checkv("fetch_addr", v_addr, m_pc);
            check1("fetch_exec", v_exec, 1'b0);
            stop = (stop_at == 100 && d == 0);
            imem_ack = (d == delay);
            imem_data = (d == delay) ? word : $urandom;
            tick();
        end
        stop = 1'b0;
        imem_ack = 1'b0;
        imem_data = $urandom;
        checkv("decode_instr", v_instr, word);
        check1("decode_req", v_req, 1'b0);
        check1("decode_busy", v_busy, 1'b1);
        check1("decode_exec", v_exec, 1'b0);
        tick();
        if (exp_halt) begin
            check1("halt_halted", v_halted, 1'b1);
            check1("halt_busy", v_busy, 1'b0);
            check1("halt_we", v_we, 1'b0);
            checkv("halt_pc", v_pc, m_pc);
            checkv("halt_retired", v_ret, m_ret);
            return;
        end
        for (int e = 0; e < cur_exec; e++) begin
            check1("exec_en", v_exec, 1'b1);
            check1("exec_we", v_we, 1'b0);
            stop = (e == stop_at);
            start = ($urandom_range(0, 3) == 0);
            tick();
        end
        stop = 1'b0;
        start = 1'b0;
        check1("wb_we", v_we, exp_we);
        check1("wb_exec", v_exec, 1'b0);
        check1("wb_busy", v_busy, 1'b1);
        checkv("wb_pc", v_pc, m_pc);
        tick();
        m_pc = (m_pc + 32'd1) % cur_mod;
        m_ret = (m_ret + 32'd1) & 32'h0000_FFFF;
        checkv("next_pc", v_pc, m_pc);
        checkv("next_retired", v_ret, m_ret);
        check1("next_we", v_we, 1'b0);
        check1("next_req", v_req, !stopped);
        check1("next_busy", v_busy, !stopped);
    endtask

    task automatic random_instrs(input int count);
        logic [31:0] w;
        int          delay, stop_at, r;
        for (int i = 0; i < count; i++) begin
            delay = $urandom_range(0, cur_timeout - 1);
            if ($urandom_range(0, 11) == 0) begin
                run_instr(32'hFFFF_FFFF, delay, 1'b0, 1'b1, -1);
                do_start();
            end else begin
                w = $urandom;
                if ($urandom_range(0, 3) == 0) w[18:15] = 4'b0000;
                if (w == 32'hFFFF_FFFF) w = 32'd0;
                r = $urandom_range(0, 9);
                if (r == 0) stop_at = 100;
                else if (r == 1) stop_at = $urandom_range(0, cur_exec - 1);
                else stop_at = -1;
                run_instr(w, delay, writes_reg(w), 1'b0, stop_at);
                if (stop_at >= 0) do_start();
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a = 1'b1;  rst_b = 1'b1;  start = 1'b0;  stop = 1'b0;
        imem_ack = 1'b0;  imem_data = 32'd0;
        vecs[0] = '{32'h0308_8000, 0,  1'b1, 1'b0};
        vecs[1] = '{32'h0000_0000, 0,  1'b0, 1'b0};
        vecs[2] = '{32'h0007_8000, 2,  1'b1, 1'b0};
        vecs[3] = '{32'h0000_7FFF, 14, 1'b0, 1'b0};   // ack on last allowed cycle
        vecs[4] = '{32'h0004_0000, 1,  1'b1, 1'b0};
        vecs[5] = '{32'hFFFF_FFFF, 0,  1'b0, 1'b1};   // halt at pc 5
        vecs[6] = '{32'hFFF8_7FFF, 3,  1'b0, 1'b0};

        // ---- instance a: default parameters ----
        use_dut(1'b0);
        tick();
        apply_reset();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check1("idle_stop_ignored", v_busy, 1'b0);
        do_start();
        for (int i = 0; i < 7; i++) begin
            run_instr(vecs[i].word, vecs[i].delay, vecs[i].we, vecs[i].halt, -1);
            if (vecs[i].halt) begin
                stop = 1'b1;
                tick();
                stop = 1'b0;
                check1("halt_stop_ignored", v_halted, 1'b1);
                checkv("halt_pc_hold", v_pc, 32'd5);
                do_start();
            end
        end

        // fetch timeout: pc 1, no ack for TIMEOUT cycles
        for (int d = 0; d < cur_timeout; d++) begin
            check1("to_req", v_req, 1'b1);
            imem_ack = 1'b0;
            tick();
        end
        check1("to_fault", v_fault, 1'b1);
        check1("to_req_low", v_req, 1'b0);
        check1("to_busy", v_busy, 1'b0);
        checkv("to_pc", v_pc, m_pc);
        checkv("to_retired", v_ret, m_ret);
        stop = 1'b1;
        tick();
        tick();
        stop = 1'b0;
        check1("fault_stop_ignored", v_fault, 1'b1);
        do_start();
        random_instrs(150);

        // ---- instance b: PC_W=2, START_PC=2, EXEC_CYCLES=3, TIMEOUT=3 ----
        rst_a = 1'b1;
        use_dut(1'b1);
        apply_reset();
        do_start();
        for (int i = 0; i < 3; i++) begin
            run_instr(32'h0308_8000, i, 1'b1, 1'b0, -1);   // pc 2 -> 3 -> 0 -> 1
        end
        checkv("wrap_pc", v_pc, 32'd1);

        // reset in the middle of EXECUTE
        imem_ack = 1'b1;
        imem_data = 32'h0007_8000;
        tick();
        imem_ack = 1'b0;
        tick();
        check1("pre_rst_exec", v_exec, 1'b1);
        tick();
        check1("pre_rst_exec2", v_exec, 1'b1);
        #2;
        rst_b = 1'b1;
        #1;
        check_reset_values("midrst");
        for (int i = 0; i < 4; i++) begin
            tick();
            check1("midrst_no_we", v_we, 1'b0);
        end
        rst_b = 1'b0;
        tick();
        check1("post_rst_idle", v_busy, 1'b0);

        // stop during EXECUTE and during FETCH (sticky)
        do_start();
        run_instr(32'h0308_8000, 0, 1'b1, 1'b0, 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check1("stop_idle_ignored", v_busy, 1'b0);
        do_start();
        run_instr(32'h0000_0000, 2, 1'b0, 1'b0, 100);
        do_start();
        random_instrs(60);

        $display("info: final state codes a=%0d b=%0d", a_state, b_state);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
